dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: one outstanding tagged load plus posted stores on a single bus.
// Optional load-starvation guard is enabled with `define DMEM_ARB_FAIR_EN.
module dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_SIZE_W   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_req,
  input  logic [XLEN-1:0]       ld_addr,
  input  logic [MEM_SIZE_W-1:0] ld_size,
  input  logic                  st_req,
  input  logic [XLEN-1:0]       st_addr,
  input  logic [XLEN-1:0]       st_data,
  input  logic [MEM_SIZE_W-1:0] st_size,
  input  logic [3:0]            Dmem2proc_response,
  input  logic [3:0]            Dmem2proc_tag,
  input  logic [63:0]           Dmem2proc_data,
  output logic [1:0]            proc2Dmem_command,
  output logic [XLEN-1:0]       proc2Dmem_addr,
  output logic [63:0]           proc2Dmem_data,
  output logic [MEM_SIZE_W-1:0] proc2Dmem_size,
  output logic                  ld_accepted,
  output logic                  ld_done,
  output logic [XLEN-1:0]       ld_data,
  output logic                  st_done,
  output logic                  busy,
  output logic                  dbg_state
);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_e;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  // Handshake: a request is held by its owner; it is complete only in a cycle where
  // it is the presented command and Dmem2proc_response is nonzero. A zero response
  // leaves everything unchanged and the same requester is presented again.

  state_e     state;
  logic [3:0] tag_q;
  logic       lock_q;
  logic       lock_st_q;
  logic       ld_elig;
  logic       pick_ld;
  logic       pick_st;
  logic       accept;
  logic       tag_match;
  logic       starve;
  logic       unused_data;

  assign ld_elig     = ld_req && (state == IDLE);
  assign accept      = (pick_ld || pick_st) && (Dmem2proc_response != 4'h0);
  assign ld_accepted = pick_ld && accept;
  assign st_done     = pick_st && accept;
  assign tag_match   = (state == WAIT_RESP) && (Dmem2proc_tag != 4'h0) && (Dmem2proc_tag == tag_q);
  assign busy        = (state == WAIT_RESP);
  assign dbg_state   = state;
  assign unused_data = ^Dmem2proc_data;

  // A rejected winner keeps the bus until it is accepted or drops its request.
  always_comb begin
    pick_ld = 1'b0;
    pick_st = 1'b0;
    if (lock_q && lock_st_q && st_req) begin
      pick_st = 1'b1;
    end else if (lock_q && !lock_st_q && ld_elig) begin
      pick_ld = 1'b1;
    end else if (ld_elig && (!st_req || starve)) begin
      pick_ld = 1'b1;
    end else if (st_req) begin
      pick_st = 1'b1;
    end
  end

  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = 64'h0;
    proc2Dmem_size    = '0;
    if (pick_st) begin
      proc2Dmem_command = BUS_STORE;
      proc2Dmem_addr    = st_addr;
      proc2Dmem_data    = 64'(st_data);
      proc2Dmem_size    = st_size;
    end else if (pick_ld) begin
      proc2Dmem_command = BUS_LOAD;
      proc2Dmem_addr    = ld_addr;
      proc2Dmem_size    = ld_size;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tag_q     <= 4'h0;
      ld_done   <= 1'b0;
      ld_data   <= '0;
      lock_q    <= 1'b0;
      lock_st_q <= 1'b0;
    end else begin
      ld_done <= tag_match;
      if (tag_match) begin
        ld_data <= Dmem2proc_data[XLEN-1:0];
      end
      if (accept || !(pick_ld || pick_st)) begin
        lock_q <= 1'b0;
      end else begin
        lock_q    <= 1'b1;
        lock_st_q <= pick_st;
      end
      case (state)
        IDLE: begin
          if (ld_accepted) begin
            tag_q <= Dmem2proc_response;
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (tag_match) begin
            tag_q <= 4'h0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt;

  assign starve = (starve_cnt >= LIMIT);

  // Counts stores that won while an eligible load sat waiting; saturates at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!ld_req || ld_accepted) begin
      starve_cnt <= '0;
    end else if (st_done && ld_elig && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: load/store arbitration, rejection retry, tag return, reset abort.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic [3:0]  Dmem2proc_response;
  logic [3:0]  Dmem2proc_tag;
  logic [63:0] Dmem2proc_data;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [1:0]  proc2Dmem_size;
  logic        ld_accepted;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_done;
  logic        busy;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.XLEN(32), .MEM_SIZE_W(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_tag(Dmem2proc_tag),
    .Dmem2proc_data(Dmem2proc_data),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_data(proc2Dmem_data), .proc2Dmem_size(proc2Dmem_size),
    .ld_accepted(ld_accepted), .ld_done(ld_done), .ld_data(ld_data),
    .st_done(st_done), .busy(busy), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic post();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; ld_req = 1'b0; ld_addr = 32'h0; ld_size = 2'd2;
    st_req = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'd0;
    Dmem2proc_response = 4'h0; Dmem2proc_tag = 4'h0; Dmem2proc_data = 64'h0;
    #1;
    chk("rst_cmd", 64'(proc2Dmem_command), 64'd0);
    chk("rst_size", 64'(proc2Dmem_size), 64'd0);
    chk("rst_addr", 64'(proc2Dmem_addr), 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ld_done", 64'(ld_done), 64'd0);
    chk("rst_ld_data", 64'(ld_data), 64'h0);
    neg(); reset = 1'b1;

    // Load only, accepted with tag 3, data two cycles later
    neg(); ld_req = 1'b1; ld_addr = 32'h100; ld_size = 2'd2; Dmem2proc_response = 4'd3;
    #1;
    chk("l_cmd", 64'(proc2Dmem_command), 64'd1);
    chk("l_addr", 64'(proc2Dmem_addr), 64'h100);
    chk("l_data0", proc2Dmem_data, 64'h0);
    chk("l_size", 64'(proc2Dmem_size), 64'd2);
    chk("l_acc", 64'(ld_accepted), 64'd1);
    chk("l_st_done", 64'(st_done), 64'd0);
    neg(); ld_req = 1'b0; Dmem2proc_response = 4'd0;
    #1;
    chk("l_busy", 64'(busy), 64'd1);
    chk("l_dbg", 64'(dbg_state), 64'd1);
    chk("l_cmd_none", 64'(proc2Dmem_command), 64'd0);
    neg(); Dmem2proc_tag = 4'd3; Dmem2proc_data = 64'h1234_5678_DEAD_BEEF;
    #1;
    chk("l_done_early", 64'(ld_done), 64'd0);
    post();
    chk("l_done", 64'(ld_done), 64'd1);
    chk("l_ld_data", 64'(ld_data), 64'hDEAD_BEEF);
    chk("l_busy_low", 64'(busy), 64'd0);
    neg(); Dmem2proc_tag = 4'd0;
    post();
    chk("l_done_pulse", 64'(ld_done), 64'd0);

    // Simultaneous requests: store first, then the load
    neg(); ld_req = 1'b1; ld_addr = 32'h104; ld_size = 2'd1;
    st_req = 1'b1; st_addr = 32'h200; st_data = 32'hCAFE_F00D; st_size = 2'd2;
    Dmem2proc_response = 4'd5;
    #1;
    chk("b_cmd_st", 64'(proc2Dmem_command), 64'd2);
    chk("b_addr_st", 64'(proc2Dmem_addr), 64'h200);
    chk("b_data_st", proc2Dmem_data, 64'h0000_0000_CAFE_F00D);
    chk("b_st_done", 64'(st_done), 64'd1);
    chk("b_ld_acc0", 64'(ld_accepted), 64'd0);
    neg(); st_req = 1'b0; Dmem2proc_response = 4'd6;
    #1;
    chk("b_cmd_ld", 64'(proc2Dmem_command), 64'd1);
    chk("b_addr_ld", 64'(proc2Dmem_addr), 64'h104);
    chk("b_size_ld", 64'(proc2Dmem_size), 64'd1);
    chk("b_data_ld", proc2Dmem_data, 64'h0);
    chk("b_ld_acc", 64'(ld_accepted), 64'd1);
    neg(); ld_req = 1'b0; Dmem2proc_response = 4'd0;
    Dmem2proc_tag = 4'd0; Dmem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF;
    post();
    chk("b_tag0_nomatch", 64'(ld_done), 64'd0);
    chk("b_tag0_busy", 64'(busy), 64'd1);
    neg(); Dmem2proc_tag = 4'd6; Dmem2proc_data = 64'h0000_0000_0BAD_CAFE;
    post();
    chk("b_done", 64'(ld_done), 64'd1);
    chk("b_ld_data", 64'(ld_data), 64'h0BAD_CAFE);
    neg(); Dmem2proc_tag = 4'd0;

    // Rejected load re-presented three times; a late store must not steal the bus
    for (int i = 0; i < 3; i++) begin
      neg(); ld_req = 1'b1; ld_addr = 32'h300; Dmem2proc_response = 4'd0;
      st_req = (i == 2);
      #1;
      chk("r_cmd", 64'(proc2Dmem_command), 64'd1);
      chk("r_addr", 64'(proc2Dmem_addr), 64'h300);
      chk("r_acc", 64'(ld_accepted), 64'd0);
      chk("r_st_done", 64'(st_done), 64'd0);
      post();
      chk("r_busy", 64'(busy), 64'd0);
    end
    neg(); Dmem2proc_response = 4'd2;
    #1;
    chk("r_cmd4", 64'(proc2Dmem_command), 64'd1);
    chk("r_acc4", 64'(ld_accepted), 64'd1);
    chk("r_st_done4", 64'(st_done), 64'd0);
    neg(); st_req = 1'b0; ld_req = 1'b1; Dmem2proc_response = 4'd9;
    #1;
    chk("w_ld_ignored", 64'(proc2Dmem_command), 64'd0);
    chk("w_ld_acc0", 64'(ld_accepted), 64'd0);

    // Store accepted in the same cycle the outstanding load's tag returns
    neg(); ld_req = 1'b0; st_req = 1'b1; st_addr = 32'h500; st_data = 32'h5555_AAAA;
    Dmem2proc_response = 4'd7; Dmem2proc_tag = 4'd2; Dmem2proc_data = 64'hAAAA_BBBB_1111_2222;
    #1;
    chk("m_cmd_st", 64'(proc2Dmem_command), 64'd2);
    chk("m_st_done", 64'(st_done), 64'd1);
    chk("m_ld_done0", 64'(ld_done), 64'd0);
    post();
    chk("m_ld_done", 64'(ld_done), 64'd1);
    chk("m_ld_data", 64'(ld_data), 64'h1111_2222);
    chk("m_busy", 64'(busy), 64'd0);
    neg(); st_req = 1'b0; Dmem2proc_tag = 4'd0; Dmem2proc_response = 4'd0;

    // Both requests held continuously
`ifdef DMEM_ARB_FAIR_EN
    for (int i = 0; i < 4; i++) begin
      neg(); st_req = 1'b1; ld_req = 1'b1; ld_addr = 32'h600; Dmem2proc_response = 4'd1;
      #1;
      chk("f_cmd_st", 64'(proc2Dmem_command), 64'd2);
      chk("f_st_done", 64'(st_done), 64'd1);
    end
    neg();
    #1;
    chk("f_cmd_ld", 64'(proc2Dmem_command), 64'd1);
    chk("f_ld_acc", 64'(ld_accepted), 64'd1);
    neg(); ld_req = 1'b0; st_req = 1'b0; Dmem2proc_response = 4'd0; Dmem2proc_tag = 4'd1;
    post();
    chk("f_done", 64'(ld_done), 64'd1);
    neg(); Dmem2proc_tag = 4'd0;
`else
    for (int i = 0; i < 8; i++) begin
      neg(); st_req = 1'b1; ld_req = 1'b1; ld_addr = 32'h600; Dmem2proc_response = 4'd1;
      #1;
      chk("s_cmd_st", 64'(proc2Dmem_command), 64'd2);
      chk("s_st_done", 64'(st_done), 64'd1);
      chk("s_ld_acc", 64'(ld_accepted), 64'd0);
    end
    neg(); ld_req = 1'b0; st_req = 1'b0; Dmem2proc_response = 4'd0;
`endif

    // Reset while a load is outstanding; the old tag must be ignored afterwards
    neg(); ld_req = 1'b1; ld_addr = 32'h400; Dmem2proc_response = 4'd4;
    #1;
    chk("x_acc", 64'(ld_accepted), 64'd1);
    neg(); ld_req = 1'b0; Dmem2proc_response = 4'd0;
    #1;
    chk("x_busy", 64'(busy), 64'd1);
    neg(); reset = 1'b0;
    #1;
    chk("x_rst_busy", 64'(busy), 64'd0);
    chk("x_rst_data", 64'(ld_data), 64'h0);
    neg(); reset = 1'b1; Dmem2proc_tag = 4'd4; Dmem2proc_data = 64'h0000_0000_7777_8888;
    #1;
    chk("x_busy_after", 64'(busy), 64'd0);
    post();
    chk("x_no_done", 64'(ld_done), 64'd0);
    chk("x_no_data", 64'(ld_data), 64'h0);
    neg(); Dmem2proc_tag = 4'd0;
    post();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
